// File: rtl/cross_switch_nxn.sv
// N x N crossbar with one registered slot and a round-robin arbiter per output; words with an out-of-range destination are dropped and counted.
// Latency is 1 cycle in to out; in_ready drops while the target slot is full and unread.
module cross_switch_nxn #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N*WIDTH-1:0]  in_data,
    input  logic [N*SELW-1:0]   in_dest,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    output logic [N*WIDTH-1:0]  out_data,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [CNTW-1:0]     drop_cnt
);

    logic [N-1:0][WIDTH-1:0] out_data_q, out_data_d;
    logic [N-1:0]            out_valid_q, out_valid_d;
    logic [N-1:0][SELW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]         drop_cnt_q, drop_cnt_d;

    logic [N-1:0]            can_load;
    logic [N-1:0]            grant_vld;
    logic [N-1:0][SELW-1:0]  grant_idx;
    logic [N-1:0]            drop;
    logic [CNTW+4:0]         drop_sum;

    assign can_load = ~out_valid_q | out_ready;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = '0;
        grant_idx = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q[j]) + k;
                if (idx >= N) idx = idx - N;
                if (!grant_vld[j] && in_valid[idx] && (int'(in_dest[idx*SELW +: SELW]) == j)) begin
                    grant_vld[j] = 1'b1;
                    grant_idx[j] = SELW'(idx);
                end
            end
        end
    end

    // rst_n masks every handshake so nothing is accepted while in reset.
    always_comb begin
        int dst;
        dst      = 0;
        in_ready = '0;
        drop     = '0;
        for (int i = 0; i < N; i++) begin
            dst = int'(in_dest[i*SELW +: SELW]);
            if (dst >= N) begin
                drop[i]     = in_valid[i] && rst_n;
                in_ready[i] = in_valid[i] && rst_n;
            end else begin
                for (int j = 0; j < N; j++) begin
                    if (dst == j) begin
                        in_ready[i] = rst_n && grant_vld[j] && can_load[j]
                                      && (int'(grant_idx[j]) == i);
                    end
                end
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        for (int j = 0; j < N; j++) begin
            if (can_load[j]) begin
                if (grant_vld[j]) begin
                    out_data_d[j]  = in_data[int'(grant_idx[j])*WIDTH +: WIDTH];
                    out_valid_d[j] = 1'b1;
                    ptr_d[j]       = (int'(grant_idx[j]) == N-1) ? '0 : grant_idx[j] + 1'b1;
                end else begin
                    out_valid_d[j] = 1'b0;
                end
            end
        end
    end

    // Extra headroom bits let the sum overshoot before saturating.
    always_comb begin
        drop_sum = {5'd0, drop_cnt_q};
        for (int i = 0; i < N; i++) begin
            drop_sum = drop_sum + (CNTW+5)'(drop[i]);
        end
        drop_cnt_d = (drop_sum > {5'd0, {CNTW{1'b1}}}) ? {CNTW{1'b1}} : drop_sum[CNTW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            ptr_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cross_switch_nxn.sv
// Bench for cross_switch_nxn: 4-port instance for routing, arbitration, backpressure and reset; 3-port instance for drop counting.
module tb_cross_switch_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_data;
    logic [7:0]  in_dest;
    logic [3:0]  in_valid, in_ready, out_valid, out_ready;
    logic [31:0] out_data;
    logic [15:0] drop_cnt;

    logic [23:0] d_in_data, d_out_data;
    logic [5:0]  d_in_dest;
    logic [2:0]  d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [1:0]  d_drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [4][$];

    cross_switch_nxn #(.WIDTH(8), .N(4), .SELW(2), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    cross_switch_nxn #(.WIDTH(8), .N(3), .SELW(2), .CNTW(2)) u_drop (
        .clk(clk), .rst_n(rst_n),
        .in_data(d_in_data), .in_dest(d_in_dest), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .drop_cnt(d_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int i, input logic [7:0] d, input logic [1:0] dst);
        in_data[i*8 +: 8] = d;
        in_dest[i*2 +: 2] = dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every output handshake must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int j = 0; j < 4; j++) begin
                    if (out_valid[j] && out_ready[j]) begin
                        if (exp_q[j].size() == 0)
                            chk($sformatf("out%0d_unexpected", j), 32'(out_valid[j]), 32'h0);
                        else
                            chk($sformatf("out%0d_data", j), 32'(out_data[j*8 +: 8]),
                                32'(exp_q[j].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] cval [3];
        logic [3:0] crdy [3];
        logic [1:0] dexp [5];
        logic [7:0] bd;
        logic       acc;
        cval = '{8'h11, 8'h22, 8'h33};
        crdy = '{4'b0001, 4'b0010, 4'b1000};
        dexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; in_data = '0; in_dest = '0; in_valid = 4'hF; out_ready = 4'h0;
        d_in_data = '0; d_in_dest = '0; d_in_valid = '0; d_out_ready = 3'h7;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_d_drop_cnt", 32'(d_drop_cnt), 32'h0);
        step();
        rst_n = 1'b1; in_valid = 4'h0; out_ready = 4'hF;

        // Single path
        step();
        put(0, 8'hA5, 2'd2); in_valid = 4'b0001; exp_q[2].push_back(8'hA5);
        @(negedge clk); chk("single_rdy", 32'(in_ready), 32'h1);
        step(); in_valid = 4'h0;
        @(negedge clk);
        chk("single_vld", 32'(out_valid), 32'h4);
        chk("single_dat", 32'(out_data[23:16]), 32'hA5);
        step();
        @(negedge clk); chk("single_clr", 32'(out_valid), 32'h0);

        // Contention on output 1: order 0,1,3 repeating
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                put(0, 8'h11, 2'd1); put(1, 8'h22, 2'd1); put(3, 8'h33, 2'd1);
                in_valid = 4'b1011;
            end
            exp_q[1].push_back(cval[c % 3]);
            @(negedge clk); chk($sformatf("cont_rdy%0d", c), 32'(in_ready), 32'(crdy[c % 3]));
        end
        step(); in_valid = 4'h0;
        step();
        @(negedge clk); chk("cont_clr", 32'(out_valid), 32'h0);

        // Permutation
        step();
        put(0, 8'h10, 2'd3); put(1, 8'h20, 2'd2); put(2, 8'h30, 2'd1); put(3, 8'h40, 2'd0);
        in_valid = 4'hF;
        exp_q[3].push_back(8'h10); exp_q[2].push_back(8'h20);
        exp_q[1].push_back(8'h30); exp_q[0].push_back(8'h40);
        @(negedge clk); chk("perm_rdy", 32'(in_ready), 32'hF);
        step(); in_valid = 4'h0;
        @(negedge clk);
        chk("perm_dat", out_data, 32'h10203040);
        chk("perm_vld", 32'(out_valid), 32'hF);
        step();

        // Backpressure on output 2 for 5 cycles
        for (int c = 0; c < 9; c++) begin
            step();
            bd  = 8'h50 + ((c == 0) ? 8'd0 : (c <= 5) ? 8'd1 : 8'(c - 4));
            acc = (c == 0) || (c >= 5);
            put(0, bd, 2'd2); in_valid = 4'b0001;
            out_ready = (c < 5) ? 4'b1011 : 4'hF;
            if (acc) exp_q[2].push_back(bd);
            @(negedge clk);
            chk($sformatf("bp_rdy%0d", c), 32'(in_ready[0]), 32'(acc));
            if (c >= 1 && c <= 4) begin
                chk($sformatf("bp_hold%0d", c), 32'(out_data[23:16]), 32'h50);
                chk($sformatf("bp_vld%0d", c), 32'(out_valid[2]), 32'h1);
            end
        end
        step(); in_valid = 4'h0;
        step();
        @(negedge clk); chk("bp_clr", 32'(out_valid), 32'h0);

        // Reset mid-stream with all outputs full
        step();
        for (int i = 0; i < 4; i++) put(i, 8'(8'h60 + i), 2'(i));
        in_valid = 4'hF; out_ready = 4'h0;
        @(negedge clk); chk("fill_rdy", 32'(in_ready), 32'hF);
        step();
        put(0, 8'h70, 2'd0); put(1, 8'h71, 2'd0); put(2, 8'h72, 2'd2); put(3, 8'h73, 2'd2);
        chk("full_vld", 32'(out_valid), 32'hF);
        chk("full_rdy", 32'(in_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(out_valid), 32'h0);
        chk("mrst_dat", out_data, 32'h0);
        chk("mrst_drop", 32'(drop_cnt), 32'h0);
        chk("mrst_rdy", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1; out_ready = 4'hF;
        exp_q[0].push_back(8'h70); exp_q[2].push_back(8'h72);
        @(negedge clk); chk("post_rst_rdy", 32'(in_ready), 32'h5);
        step(); in_valid = 4'h0;
        step();
        @(negedge clk); chk("post_rst_clr", 32'(out_valid), 32'h0);

        // Drops on the 3-port instance
        step();
        for (int c = 0; c < 5; c++) begin
            d_in_valid = 3'b001; d_in_dest[1:0] = 2'd3; d_in_data[7:0] = 8'(c);
            @(negedge clk);
            chk($sformatf("drop_rdy%0d", c), 32'(d_in_ready[0]), 32'h1);
            chk($sformatf("drop_vld%0d", c), 32'(d_out_valid), 32'h0);
            step();
            chk($sformatf("drop_cnt%0d", c), 32'(d_drop_cnt), 32'(dexp[c]));
        end
        d_in_valid = 3'b000;
        step();
        chk("drop_cnt_hold", 32'(d_drop_cnt), 32'h3);
        chk("main_drop_cnt", 32'(drop_cnt), 32'h0);

        for (int j = 0; j < 4; j++) chk($sformatf("q%0d_left", j), 32'(exp_q[j].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
